// File: rtl/tap_delay_pkg.sv
// Shared types and defaults for the tap delay scheduler and its slot chain.
package tap_delay_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic                     valid;
        logic [WIDTH_DEFAULT-1:0] data;
        logic                     tag;
    } slot_t;

endpackage

// File: rtl/tap_slot_chain.sv
// Shift-down slot pipeline with one indexed write port and a registered count of live slots.
module tap_slot_chain
    import tap_delay_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_idx,
    input  slot_t            wr_slot,
    output slot_t            head,
    output logic [DEPTH-1:0] valids,
    output logic [DW:0]      count
);

    slot_t      slot_q [DEPTH];
    slot_t      slot_d [DEPTH];
    logic [DW:0] count_d;

    // Write wins over the shift; the arbiter guarantees the shifted-in slot was empty.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) slot_d[k] = '0;
        for (int k = 0; k < DEPTH - 1; k++) slot_d[k] = slot_q[k+1];
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_en && wr_idx == DW'(k)) slot_d[k] = wr_slot;
            count_d = count_d + {{DW{1'b0}}, slot_d[k].valid};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
            count <= '0;
        end else begin
            slot_q <= slot_d;
            count  <= count_d;
        end
    end

    assign head = slot_q[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_vld
        assign valids[k] = slot_q[k].valid;
    end

endmodule

// File: rtl/tap_delay_scheduler.sv
// Two-requester round-robin front end that places each sample at its delay tap in a shared slot chain.
module tap_delay_scheduler
    import tap_delay_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [DW-1:0]    req0_delay,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [DW-1:0]    req1_delay,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_tag,
    output logic [DW:0]      inflight
);

    logic [DEPTH-1:0] valids;
    slot_t            head;
    slot_t            wr_slot;
    logic [DW-1:0]    wr_idx;
    logic             rr_ptr;
    logic             elig0, elig1;
    logic             gnt0, gnt1;

    // A delay d lands in slot[d], so slot[d+1] must be empty or it would shift onto the write.
    function automatic logic eligible(input logic vld, input logic [DW-1:0] dly,
                                      input logic [DEPTH-1:0] vv);
        int d;
        d = int'(dly);
        if (!vld || d > DEPTH - 1) return 1'b0;
        if (d == DEPTH - 1) return 1'b1;
        return !vv[d+1];
    endfunction

    assign elig0 = !areset && eligible(req0_valid, req0_delay, valids);
    assign elig1 = !areset && eligible(req1_valid, req1_delay, valids);

    assign gnt0 = elig0 && (!elig1 || rr_ptr == REQ0);
    assign gnt1 = elig1 && (!elig0 || rr_ptr == REQ1);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)    rr_ptr <= REQ0;
        else if (gnt0) rr_ptr <= ~REQ0;
        else if (gnt1) rr_ptr <= ~REQ1;
    end

    always_comb begin
        wr_slot       = '0;
        wr_slot.valid = 1'b1;
        if (gnt1) begin
            wr_slot.data = req1_data;
            wr_slot.tag  = REQ1;
            wr_idx       = req1_delay;
        end else begin
            wr_slot.data = req0_data;
            wr_slot.tag  = REQ0;
            wr_idx       = req0_delay;
        end
    end

    tap_slot_chain #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_chain (
        .clk    (clk),
        .areset (areset),
        .wr_en  (gnt0 | gnt1),
        .wr_idx (wr_idx),
        .wr_slot(wr_slot),
        .head   (head),
        .valids (valids),
        .count  (inflight)
    );

    assign out_valid = head.valid;
    assign out_data  = head.data;
    assign out_tag   = head.tag;

endmodule

// File: tb/tb_tap_delay_scheduler.sv
// Directed vector bench for tap_delay_scheduler: table of per-cycle stimulus and expectations plus reset sequences.
module tb_tap_delay_scheduler;

    logic       clk = 1'b0;
    logic       areset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic [1:0] req0_delay, req1_delay;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_tag;
    logic [7:0] out_data;
    logic [2:0] inflight;

    int checks = 0;
    int errors = 0;

    tap_delay_scheduler dut (
        .clk       (clk),
        .areset    (areset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_delay(req0_delay),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_delay(req1_delay),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic [1:0] l0;
        logic       v1;
        logic [7:0] d1;
        logic [1:0] l1;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic       ot;
        logic [2:0] inf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v0, logic [7:0] d0, logic [1:0] l0,
                                logic v1, logic [7:0] d1, logic [1:0] l1,
                                logic r0, logic r1, logic ov, logic [7:0] od,
                                logic ot, logic [2:0] inf);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.ot = ot; v.inf = inf;
        return v;
    endfunction

    // Idle cycle: no requests, only the post-edge outputs are specified.
    function automatic vec_t idle(logic ov, logic [7:0] od, logic ot, logic [2:0] inf);
        return mk(0, 8'h00, 2'd0, 0, 8'h00, 2'd0, 0, 0, ov, od, ot, inf);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive after the falling edge, check readys before the rising edge, outputs just after it.
    task automatic apply(input vec_t v, input int idx);
        string s;
        @(negedge clk);
        req0_valid = v.v0; req0_data = v.d0; req0_delay = v.l0;
        req1_valid = v.v1; req1_data = v.d1; req1_delay = v.l1;
        #1;
        s = $sformatf("vec%0d", idx);
        chk({s, " req0_ready"}, 32'(req0_ready), 32'(v.r0));
        chk({s, " req1_ready"}, 32'(req1_ready), 32'(v.r1));
        @(posedge clk);
        #1;
        chk({s, " out_valid"}, 32'(out_valid), 32'(v.ov));
        if (v.ov) begin
            chk({s, " out_data"}, 32'(out_data), 32'(v.od));
            chk({s, " out_tag"}, 32'(out_tag), 32'(v.ot));
        end
        chk({s, " inflight"}, 32'(inflight), 32'(v.inf));
    endtask

    initial begin
        areset     = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hFF; req0_delay = 2'd3;
        req1_valid = 1'b1; req1_data = 8'hEE; req1_delay = 2'd3;
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_tag", 32'(out_tag), 32'd0);
        chk("rst inflight", 32'(inflight), 32'd0);
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        areset = 1'b0;

        // Contention, rr_ptr starts at 0: grants 0,1,0,1, outputs 3 cycles after each grant.
        vecs.push_back(mk(1, 8'hC0, 2, 1, 8'hC1, 2, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 8'hC0, 2, 1, 8'hC1, 2, 0, 1, 0, 8'h00, 0, 2));
        vecs.push_back(mk(1, 8'hC0, 2, 1, 8'hC1, 2, 1, 0, 1, 8'hC0, 0, 3));
        vecs.push_back(mk(1, 8'hC0, 2, 1, 8'hC1, 2, 0, 1, 1, 8'hC1, 1, 3));
        vecs.push_back(idle(1, 8'hC0, 0, 2));
        vecs.push_back(idle(1, 8'hC1, 1, 1));
        vecs.push_back(idle(0, 8'h00, 0, 0));
        // Single-requester latency: d=0 then d=3.
        vecs.push_back(mk(1, 8'hA5, 0, 0, 8'h00, 0, 1, 0, 1, 8'hA5, 0, 1));
        vecs.push_back(mk(1, 8'h3C, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(idle(0, 8'h00, 0, 1));
        vecs.push_back(idle(0, 8'h00, 0, 1));
        vecs.push_back(idle(1, 8'h3C, 0, 1));
        vecs.push_back(idle(0, 8'h00, 0, 0));
        // Slot conflict: req1 d=1 blocked while slot[2] holds req0's sample.
        vecs.push_back(mk(1, 8'h55, 2, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h66, 1, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h66, 1, 0, 1, 1, 8'h55, 0, 2));
        vecs.push_back(idle(1, 8'h66, 1, 1));
        vecs.push_back(idle(0, 8'h00, 0, 0));
        // Reordering: later d=0 leaves before earlier d=3.
        vecs.push_back(mk(1, 8'h11, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 8'h22, 0, 0, 1, 1, 8'h22, 1, 2));
        vecs.push_back(idle(0, 8'h00, 0, 1));
        vecs.push_back(idle(1, 8'h11, 0, 1));
        vecs.push_back(idle(0, 8'h00, 0, 0));
        // Full pipeline: short delays stall, delay 3 still granted, then drain.
        vecs.push_back(mk(1, 8'h01, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 8'h02, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 2));
        vecs.push_back(mk(1, 8'h03, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 3));
        vecs.push_back(mk(1, 8'h04, 3, 0, 8'h00, 0, 1, 0, 1, 8'h01, 0, 4));
        vecs.push_back(mk(1, 8'h77, 1, 1, 8'hE1, 3, 0, 1, 1, 8'h02, 0, 4));
        vecs.push_back(mk(1, 8'h77, 2, 0, 8'h00, 0, 0, 0, 1, 8'h03, 0, 3));
        vecs.push_back(idle(1, 8'h04, 0, 2));
        vecs.push_back(idle(1, 8'hE1, 1, 1));
        vecs.push_back(idle(0, 8'h00, 0, 0));
        // Three samples in flight ahead of the mid-stream reset.
        vecs.push_back(mk(1, 8'h91, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 8'h92, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 2));
        vecs.push_back(mk(1, 8'h93, 3, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 3));
        vecs.push_back(idle(1, 8'h91, 0, 3));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset mid-cycle must clear outputs without waiting for an edge.
        #2;
        areset = 1'b1;
        req0_valid = 1'b1; req0_delay = 2'd0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst inflight", 32'(inflight), 32'd0);
        chk("midrst req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) apply(idle(0, 8'h00, 0, 0), 100 + i);

        // rr_ptr returned to 0 by reset: req0 wins a tie.
        apply(mk(1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 0, 8'h00, 0, 1), 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tap_delay_scheduler.md
# tap_delay_scheduler

Shares one tapped delay pipeline between two requesters. Each accepted sample emerges on a single output exactly `delay+1` cycles after acceptance. The block arbitrates round-robin among requesters whose output slot is free, so output collisions cannot occur. It sits in front of the 8-bit register-chain datapath and owns that datapath's tap selection per sample instead of a static `sel`.

## Interface
- `WIDTH`, 8, sample width.
- `DEPTH`, 4, pipeline slots; legal delays are 0..DEPTH-1.
- `DW`, $clog2(DEPTH) = 2, delay field width (derived; not overridden).
- `clk`  in  1  rising-edge clock.
- `areset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a sample.
- `req0_data`  in  WIDTH  requester 0 sample.
- `req0_delay`  in  DW  requested extra delay, 0..DEPTH-1.
- `req0_ready`  out  1  grant; transfer occurs when valid & ready are both high at the rising edge.
- `req1_valid`, `req1_data`, `req1_delay`, `req1_ready`  same as requester 0, for requester 1.
- `out_valid`  out  1  output slot carries a sample.
- `out_data`  out  WIDTH  sample.
- `out_tag`  out  1  id of the requester that supplied the sample.
- `inflight`  out  DW+1  number of valid pipeline slots, 0..DEPTH.

## Operation
- **Pipeline:** `slot[0..DEPTH-1]`, each holding {valid, data, tag}. Every edge, `slot[k] <= slot[k+1]`; `slot[DEPTH-1]` is refilled with invalid.
- **Outputs:** `out_valid`, `out_data` and `out_tag` are driven directly from `slot[0]`.
- **Accept:** an accepted sample with delay d is written into `slot[d]` at that edge. The write overrides the shift into `slot[d]`.
- **Eligibility:** requester i is eligible when `reqi_valid` is high and the slot that would shift into `slot[d]` is empty.
  - For d < DEPTH-1, that means `slot[d+1].valid == 0`, sampled before the edge.
  - For d = DEPTH-1, the requester is always slot-free.
- **Grant rule:** at most one grant per cycle. `reqi_ready` is combinational from valid, delay, pipeline state and pointer.
  - Only one requester eligible: that requester is granted.
  - Both eligible: the requester named by `rr_ptr` is granted.
  - Neither eligible: both readys are low.
- **Round-robin:** after any grant, `rr_ptr <= ~granted_id`. With no grant, `rr_ptr` holds.
- **Ready with valid low:** `reqi_ready` is low whenever `reqi_valid` is low. Requesters must hold data and delay stable while valid is high and ready is low.
- **inflight:** a registered popcount of slot valids, consistent with the slot contents after each edge.
- **Reset:** asynchronous and immediate, including mid-operation. All slot valids clear, in-flight samples are discarded, `rr_ptr = 0`.
- **Reset values:** `out_valid = 0`, `out_data = 0`, `out_tag = 0`, `inflight = 0`, readys low.
- **Widths:** `inflight` saturation is impossible, since it is bounded by DEPTH. A delay above DEPTH-1 cannot occur with the default DEPTH=4. For a non-power-of-2 DEPTH, such a delay is treated as ineligible.

## Timing
- **Latency:** a sample accepted at edge t with delay d has `out_valid = 1` during the cycle after edge t+d, i.e. d+1 cycles after its accept cycle.
- **Throughput:** one sample per cycle total, in the best case.
- **Order:** output order is by departure slot, not acceptance order. A later d=0 can exit before an earlier d=3.
- **Simultaneous shift and write:** the eligibility rule guarantees `slot[d+1]` is empty, so no data is lost.
- **Loser stalls:** a losing eligible requester is granted no later than the next cycle in which it remains eligible (fairness by `rr_ptr`).

## Structure
- **Shared package `tap_delay_pkg`:**
  - `slot_t` struct {valid, data[WIDTH-1:0], tag}.
  - Requester-id constants `REQ0 = 0`, `REQ1 = 1`.
  - Default `WIDTH` and `DEPTH` localparams.
- **Sub-module `tap_slot_chain`:** slot registers with shift, indexed write port (`wr_en`, `wr_idx`, `wr_slot`), valid vector out and popcount.
- **Top level:** eligibility, arbiter and `rr_ptr`.

## Test plan
- **Reset state:** assert `areset` mid-stream with three samples in flight. Require `out_valid = 0` and `inflight = 0` immediately, with no stale output after release.
- **Single-requester latency:** req0 sends 0xA5 with delay 0, then 0x3C with delay 3. Require 0xA5 (tag 0) 1 cycle later and 0x3C (tag 0) 4 cycles later.
- **Contention fairness:** both requesters valid every cycle with delay 2, starting from `rr_ptr = 0`. Require grants alternating 0,1,0,1. Require each output tag to match the granted sequence 3 cycles later.
- **Slot conflict:** req0 is accepted with delay 2. Next cycle, req1 asks for delay 1 (slot[2] now occupied). Require `req1_ready = 0` that cycle, and the grant on the following cycle.
- **Reordering:** cycle 0: req0 0x11, delay 3. Cycle 1: req1 0x22, delay 0. Require output 0x22/tag 1 at cycle 2 and 0x11/tag 0 at cycle 4.
- **Full pipeline:** fill slots 0..3, then check `inflight = 4`. Requests with delay 0–2 stall while requests with delay 3 remain grantable. `inflight` must decrement as the pipeline drains.
